// File: rtl/apb2ahb_pkg.sv
// Shared definitions for the APB-to-AHB bridge: FSM state encoding, HTRANS and HSIZE codes.
package apb2ahb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_ERR,
      ST_RESP
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/apb2ahb_strb_dec.sv
// Maps an APB write-strobe pattern onto an AHB transfer size and low address bits.
module apb2ahb_strb_dec
   import apb2ahb_pkg::*;
(
   input  logic [3:0] pstrb,
   output logic [2:0] hsize,
   output logic [1:0] addr_lo,
   output logic       illegal
);

   // Only naturally aligned byte, halfword and word lanes map onto a single AHB beat.
   always_comb begin
      hsize   = HSIZE_WORD;
      addr_lo = 2'b00;
      illegal = 1'b0;
      case (pstrb)
         4'b1111: hsize = HSIZE_WORD;
         4'b0011: hsize = HSIZE_HALF;
         4'b1100: begin hsize = HSIZE_HALF; addr_lo = 2'b10; end
         4'b0001: hsize = HSIZE_BYTE;
         4'b0010: begin hsize = HSIZE_BYTE; addr_lo = 2'b01; end
         4'b0100: begin hsize = HSIZE_BYTE; addr_lo = 2'b10; end
         4'b1000: begin hsize = HSIZE_BYTE; addr_lo = 2'b11; end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/apb2ahb_bridge.sv
// APB slave to single-beat AHB master bridge. Define APB2AHB_PSTRB_EN to add PSTRB-driven
// byte/halfword writes; without it every transfer is a word at a word-aligned address.
module apb2ahb_bridge
   import apb2ahb_pkg::*;
#(
   parameter int ADDRWIDTH = 16,
   parameter int DATAWIDTH = 32
)
(
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 PSEL,
   input  logic                 PENABLE,
   input  logic [ADDRWIDTH-1:0] PADDR,
   input  logic                 PWRITE,
   input  logic [DATAWIDTH-1:0] PWDATA,
`ifdef APB2AHB_PSTRB_EN
   input  logic [3:0]           PSTRB,
`endif
   output logic [DATAWIDTH-1:0] PRDATA,
   output logic                 PREADY,
   output logic                 PSLVERR,
   output logic [ADDRWIDTH-1:0] HADDR,
   output logic [1:0]           HTRANS,
   output logic                 HWRITE,
   output logic [2:0]           HSIZE,
   output logic [DATAWIDTH-1:0] HWDATA,
   input  logic [DATAWIDTH-1:0] HRDATA,
   input  logic                 HREADY,
   input  logic                 HRESP
);

   localparam logic [ADDRWIDTH-1:0] LOW_MASK = ADDRWIDTH'(3);

   state_t     state;
   logic       err_flag;
   logic [2:0] setup_size;
   logic [1:0] setup_lo;
   logic       setup_bad;

`ifdef APB2AHB_PSTRB_EN
   logic [2:0] strb_size;
   logic [1:0] strb_lo;
   logic       strb_bad;

   apb2ahb_strb_dec u_strb_dec (
      .pstrb   (PSTRB),
      .hsize   (strb_size),
      .addr_lo (strb_lo),
      .illegal (strb_bad)
   );

   // Reads always move a full word regardless of the strobes on the bus.
   always_comb begin
      setup_size = HSIZE_WORD;
      setup_lo   = 2'b00;
      setup_bad  = 1'b0;
      if (PWRITE) begin
         setup_size = strb_size;
         setup_lo   = strb_lo;
         setup_bad  = strb_bad;
      end
   end
`else
   assign setup_size = HSIZE_WORD;
   assign setup_lo   = 2'b00;
   assign setup_bad  = 1'b0;
`endif

   assign PSLVERR = err_flag;

   // Transfer sequencer: every bus output is a register updated on state transitions, so the
   // AHB address phase lasts exactly as long as the slave stalls it and PREADY is a one-cycle pulse.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state    <= ST_IDLE;
         HTRANS   <= HTRANS_IDLE;
         HADDR    <= '0;
         HWRITE   <= 1'b0;
         HSIZE    <= HSIZE_WORD;
         HWDATA   <= '0;
         PRDATA   <= '0;
         PREADY   <= 1'b0;
         err_flag <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (PSEL && !PENABLE) begin
                  if (setup_bad) begin
                     state    <= ST_RESP;
                     PREADY   <= 1'b1;
                     err_flag <= 1'b1;
                     PRDATA   <= '0;
                  end else begin
                     state  <= ST_ADDR;
                     HTRANS <= HTRANS_NONSEQ;
                     HADDR  <= (PADDR & ~LOW_MASK) | {{(ADDRWIDTH-2){1'b0}}, setup_lo};
                     HWRITE <= PWRITE;
                     HSIZE  <= setup_size;
                     HWDATA <= PWDATA;
                  end
               end
            end
            ST_ADDR: begin
               if (HREADY) begin
                  state  <= ST_DATA;
                  HTRANS <= HTRANS_IDLE;
               end
            end
            ST_DATA: begin
               if (HREADY) begin
                  state    <= ST_RESP;
                  PREADY   <= 1'b1;
                  err_flag <= HRESP;
                  PRDATA   <= (HWRITE || HRESP) ? '0 : HRDATA;
               end else if (HRESP) begin
                  state <= ST_ERR;
               end
            end
            ST_ERR: begin
               if (HREADY) begin
                  state    <= ST_RESP;
                  PREADY   <= 1'b1;
                  err_flag <= 1'b1;
                  PRDATA   <= '0;
               end
            end
            ST_RESP: begin
               state    <= ST_IDLE;
               PREADY   <= 1'b0;
               err_flag <= 1'b0;
               PRDATA   <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/apb2ahb_bridge.md
APB2AHB_BRIDGE -- requirements
Module: apb2ahb_bridge

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 16: APB/AHB address width.
REQ-002 SHALL have parameter DATAWIDTH, default 32: data width; only 32 is supported.
REQ-003 HCLK  in  1  clock; all logic on rising edge.
REQ-004 HRESETn  in  1  reset; asynchronous, active-low.
REQ-005 PSEL  in  1  APB select.
REQ-006 PENABLE  in  1  APB access phase.
REQ-007 PADDR  in  ADDRWIDTH  APB address.
REQ-008 PWRITE  in  1  APB write.
REQ-009 PWDATA  in  DATAWIDTH  APB write data.
REQ-010 PSTRB  in  4  APB write strobes; present only with APB2AHB_PSTRB_EN.
REQ-011 PRDATA  out  DATAWIDTH  APB read data.
REQ-012 PREADY  out  1  APB transfer complete.
REQ-013 PSLVERR  out  1  APB error, valid only with PREADY.
REQ-014 HADDR  out  ADDRWIDTH  AHB address.
REQ-015 HTRANS  out  2  AHB transfer type; IDLE=2'b00, NONSEQ=2'b10 only.
REQ-016 HWRITE  out  1  AHB write.
REQ-017 HSIZE  out  3  AHB size.
REQ-018 HWDATA  out  DATAWIDTH  AHB write data.
REQ-019 HRDATA  in  DATAWIDTH  AHB read data.
REQ-020 HREADY  in  1  AHB ready.
REQ-021 HRESP  in  1  AHB response; 0=OKAY, 1=ERROR.

Function
REQ-022 FSM states: IDLE, ADDR, DATA, ERR, RESP.
REQ-023 IDLE: PSEL=1 and PENABLE=0 sampled -> capture PADDR, PWRITE, PWDATA, size; go to ADDR. A rejected strobe pattern (REQ-036) goes to RESP instead.
REQ-024 ADDR: HTRANS=NONSEQ, HADDR/HWRITE/HSIZE from captured values; HREADY=1 -> DATA; HREADY=0 -> stay, outputs held stable.
REQ-025 DATA: HTRANS=IDLE, HWDATA=captured PWDATA (held from ADDR onward).
 - HREADY=1, HRESP=0 -> capture HRDATA (reads), go to RESP.
 - HREADY=0, HRESP=1 -> ERR.
 - HREADY=0, HRESP=0 -> stay.
REQ-026 ERR: wait for HREADY=1 (second error cycle), then go to RESP with error flag set.
REQ-027 RESP: PREADY=1 for exactly one cycle, PSLVERR=error flag, PRDATA=captured read data (0 on writes or error); always go to IDLE.
REQ-028 PREADY=0 and PSLVERR=0 in every state except RESP.
REQ-029 Zero-wait AHB slave: PREADY high in the 3rd access-phase cycle. Each AHB wait state adds one cycle.
REQ-030 Base size: HSIZE=3'b010 and HADDR[1:0]=2'b00 for every transfer.
REQ-031 PSEL dropping mid-transfer (protocol violation): the AHB transfer still completes normally, RESP is still entered for one cycle, and its result is discarded.
REQ-032 A new setup in the RESP cycle is ignored; IDLE samples the next setup.

Reset
REQ-033 HRESETn low forces, asynchronously:
 - state=IDLE, HTRANS=2'b00, HADDR=0, HWRITE=0, HSIZE=3'b010, HWDATA=0;
 - PRDATA=0, PREADY=0, PSLVERR=0, error flag=0.
REQ-034 Reset asserted mid-transfer abandons the transfer; no PREADY is produced after release until a new setup phase.

Configuration
REQ-035 Macro APB2AHB_PSTRB_EN: without it, PSTRB is absent and REQ-030 applies.
REQ-036 With APB2AHB_PSTRB_EN, writes map PSTRB as follows:
 - 1111 -> word.
 - 0011/1100 -> halfword, HADDR[1:0]=00/10.
 - one-hot -> byte, HADDR[1:0]=index of the set bit.
 - any other pattern, including 0000 -> no AHB transfer; RESP with PSLVERR=1.
 - reads ignore PSTRB and use word size.

Structure
REQ-037 Package apb2ahb_pkg SHALL hold the FSM state encoding, the HTRANS codes and the HSIZE codes.
REQ-038 Sub-module apb2ahb_strb_dec SHALL decode PSTRB into HSIZE, HADDR[1:0] and an illegal flag; it is instantiated only with APB2AHB_PSTRB_EN.

Verification
REQ-039 Write PADDR=16'h1234, PWDATA=32'hDEADBEEF, zero-wait slave -> HADDR=16'h1234, HTRANS=NONSEQ for 1 cycle, HWDATA=32'hDEADBEEF; PREADY in 3rd access cycle, PSLVERR=0.
REQ-040 Read 16'h0040, HREADY low 2 cycles in DATA, HRDATA=32'hA5A5_5A5A -> PRDATA=32'hA5A5_5A5A; PREADY in 5th access cycle.
REQ-041 Two-cycle ERROR response to a write -> PREADY=1, PSLVERR=1, PRDATA=0; next transfer completes OKAY.
REQ-042 HRESETn pulsed low during DATA -> all outputs at reset values immediately; no PREADY until a new setup phase.
REQ-043 APB2AHB_PSTRB_EN write tests:
 - PSTRB=0100, PADDR=16'h0010 -> HSIZE=3'b000, HADDR=16'h0012.
 - PSTRB=0101 -> no HTRANS activity, PSLVERR=1.
REQ-044 Back-to-back setups with no idle between APB transfers -> every transfer yields exactly one NONSEQ and one PREADY.
